sphere_hit_scheduler: RTL and testbench
=======================================

# sphere_hit_scheduler

Sequencer and arbiter for the shared, pipelined sphere-intersection datapath in RayCore. It accepts closest-hit queries from NUM_REQ ray requesters and grants one query at a time, round-robin. For the granted ray it streams every sphere index into the datapath, folds the returning results into a closest-hit record, and returns one result per query to the originating requester.

## Interface
- NUM_REQ, default 4: number of ray requesters (2..8).
- NUM_SPHERES, default 8: spheres tested per query (1..255).
- PI_W, default 8: width of the primitive index; must hold NUM_SPHERES-1.
- clk  in  1  system clock, all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester query valid.
- req_ray  in  NUM_REQ x Ray  per-requester ray; held stable while req_valid is high.
- req_ready  out  NUM_REQ  one-hot grant; a query transfers when req_valid[i] and req_ready[i] are both high.
- dp_valid  out  1  issue strobe to the datapath.
- dp_ray  out  Ray  latched ray of the current query.
- dp_index  out  PI_W  sphere index being issued.
- dp_res_valid  in  1  datapath result strobe, in issue order, arbitrary fixed latency ≥1.
- dp_res_hit  in  1  the sphere was hit with t > 0.
- dp_res_t  in  Fixed  hit distance, signed Fixed.
- dp_res_data  in  HitData  full hit record from the datapath.
- resp_valid  out  1  result valid.
- resp_id  out  $clog2(NUM_REQ)  requester that owns the result.
- resp_hit  out  1  any sphere hit.
- resp_index  out  PI_W  index of the closest sphere.
- resp_data  out  HitData  HitData of the closest sphere.
- resp_ready  in  1  consumer accepts the result.

## Operation
- The FSM has four states: IDLE, ISSUE, DRAIN, RESP.
- **IDLE:**
  - The round-robin arbiter picks the first asserted req_valid starting at rr_ptr, wrapping modulo NUM_REQ.
  - req_ready is high only for that requester, combinationally, and only while in IDLE.
  - On transfer, the block latches the ray and the id, sets rr_ptr = grant+1 (mod NUM_REQ), clears issue_cnt, ret_cnt and best_hit, and moves to ISSUE.
- **ISSUE:**
  - dp_valid = 1 and dp_index = issue_cnt; issue_cnt increments every cycle.
  - After issuing index NUM_SPHERES-1, the FSM moves to DRAIN.
- **Result fold** (applies in ISSUE and DRAIN): on dp_res_valid, ret_cnt increments.
  - The incoming result replaces the best record if dp_res_hit && (!best_hit || dp_res_t < best_t), using a signed compare.
  - On a tie the earlier (lower) index is kept.
  - The index stored for a result is ret_cnt at the time it arrives.
- **DRAIN:** when ret_cnt reaches NUM_SPHERES (including the current fold), the FSM moves to RESP. If the last result arrives while still in ISSUE, the FSM goes straight from ISSUE to RESP.
- **RESP:**
  - resp_valid = 1, and resp_* is driven from the best record.
  - When resp_ready is high, the FSM returns to IDLE.
  - resp_* is held stable while resp_valid && !resp_ready.
- dp_res_valid in IDLE or RESP, or after ret_cnt has reached NUM_SPHERES, is ignored. This discards in-flight results left over from a reset.
- No new query is granted until the current response is accepted: exactly one query is outstanding at a time.

## Timing
- **Reset (async assert):**
  - state = IDLE, rr_ptr = 0, all counters 0, best_hit = 0.
  - Outputs: req_ready = 0 until the first clk edge after release, dp_valid = 0, dp_index = 0, resp_valid = 0, resp_id = 0, resp_hit = 0, resp_index = 0, resp_data = 0.
  - Reset mid-query drops the query silently; its requester must re-request.
- Grant at cycle 0 (the handshake edge).
- dp_valid is high on cycles 1..NUM_SPHERES, with indices 0..NUM_SPHERES-1 back-to-back.
- With datapath latency L, the last result arrives at cycle NUM_SPHERES+L and resp_valid rises at cycle NUM_SPHERES+L+1.
- If resp_ready is already high, the response is accepted that same cycle; IDLE is reached on the following cycle and the next grant can happen there. Throughput is one query per NUM_SPHERES+L+2 cycles.
- The FSM does not wait on L: the transition depends only on ret_cnt.

## Test plan
- **Single query:** NUM_SPHERES=8, L=3, requester 2 valid. Only sphere 5 hits, t=0x00030000.
  - Expect req_ready=4'b0100 at cycle 0 and dp_index 0..7 on cycles 1..8.
  - Expect resp_valid at cycle 12 with resp_id=2, resp_hit=1, resp_index=5.
- **Closest hit and tie:** spheres 1, 3 and 6 hit with t=5.0, 2.0 and 2.0.
  - Expect resp_index=3 (the earlier index wins the tie).
  - With no hits, expect resp_hit=0 and resp_index=0.
- **Round-robin fairness:** all four requesters held valid.
  - Expect grants in the order 0,1,2,3,0.
  - Then drop requester 1: expect the order to continue 2,3,0,2.
- **Backpressure:** hold resp_ready=0 for 5 cycles.
  - Expect resp_* stable and no req_ready asserted.
  - Acceptance occurs on the cycle resp_ready rises.
- **Reset mid-query:** assert resetn=0 while in DRAIN with 2 results outstanding.
  - Expect all outputs to be 0 immediately.
  - The stale dp_res_valid pulses after release are ignored.
  - A new query then returns the correct result for its own ray.
- **Latency independence:** repeat the single-query case with L=1 and L=7.
  - Expect resp_valid at cycles 10 and 16 respectively, with identical results.

Source files
------------

// File: rtl/sphere_hit_scheduler.sv
// Round-robin query arbiter and sequencer for the shared sphere-intersection datapath.
package sphere_hit_pkg;
  typedef logic signed [31:0] fixed_t;

  typedef struct packed {
    fixed_t ox;
    fixed_t oy;
    fixed_t oz;
    fixed_t dx;
    fixed_t dy;
    fixed_t dz;
  } ray_t;

  typedef struct packed {
    fixed_t t;
    fixed_t nx;
    fixed_t ny;
    fixed_t nz;
  } hit_data_t;
endpackage

module sphere_hit_scheduler
  import sphere_hit_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned NUM_SPHERES = 8,
  parameter int unsigned PI_W        = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  ray_t                       req_ray [NUM_REQ],
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       dp_valid,
  output ray_t                       dp_ray,
  output logic [PI_W-1:0]            dp_index,
  input  logic                       dp_res_valid,
  input  logic                       dp_res_hit,
  input  fixed_t                     dp_res_t,
  input  hit_data_t                  dp_res_data,
  output logic                       resp_valid,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic                       resp_hit,
  output logic [PI_W-1:0]            resp_index,
  output hit_data_t                  resp_data,
  input  logic                       resp_ready
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(NUM_SPHERES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  state_t            state, state_d;
  logic              live;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   id_q;
  ray_t              ray_q;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  ret_cnt;
  logic              best_hit;
  fixed_t            best_t;
  logic [PI_W-1:0]   best_idx;
  hit_data_t         best_data;

  logic              grant_valid;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   cand;
  logic              take;
  logic              fold;
  logic              better;
  logic              last_ret;

  // First asserted requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!grant_valid && req_valid[cand]) begin
        grant_valid = 1'b1;
        grant_id    = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_d;
  end

  // Next state, grant and fold qualifiers.
  always_comb begin
    state_d   = state;
    take      = 1'b0;
    req_ready = '0;
    fold      = dp_res_valid && ((state == ISSUE) || (state == DRAIN))
                && (ret_cnt < CNT_W'(NUM_SPHERES));
    last_ret  = fold && (ret_cnt == CNT_W'(NUM_SPHERES - 1));
    better    = dp_res_hit && (!best_hit || (dp_res_t < best_t));
    case (state)
      IDLE: begin
        if (live && grant_valid) begin
          take      = 1'b1;
          req_ready = NUM_REQ'(1) << grant_id;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (last_ret)                                        state_d = RESP;
        else if (issue_cnt == CNT_W'(NUM_SPHERES - 1))       state_d = DRAIN;
      end
      DRAIN: begin
        if (last_ret) state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Query context, counters and closest-hit record.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      live      <= 1'b0;
      rr_ptr    <= '0;
      id_q      <= '0;
      ray_q     <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      best_hit  <= 1'b0;
      best_t    <= '0;
      best_idx  <= '0;
      best_data <= '0;
    end else begin
      live <= 1'b1;
      if (take) begin
        rr_ptr    <= ID_W'((32'(grant_id) + 32'd1) % NUM_REQ);
        id_q      <= grant_id;
        ray_q     <= req_ray[grant_id];
        issue_cnt <= '0;
        ret_cnt   <= '0;
        best_hit  <= 1'b0;
        best_t    <= '0;
        best_idx  <= '0;
        best_data <= '0;
      end
      if ((state == ISSUE) && (issue_cnt != CNT_W'(NUM_SPHERES - 1))) begin
        issue_cnt <= issue_cnt + CNT_W'(1);
      end
      if (fold) begin
        ret_cnt <= ret_cnt + CNT_W'(1);
        // Strict less-than keeps the lower index on a tie.
        if (better) begin
          best_hit  <= 1'b1;
          best_t    <= dp_res_t;
          best_idx  <= PI_W'(ret_cnt);
          best_data <= dp_res_data;
        end
      end
    end
  end

  // Output decode from registered state.
  always_comb begin
    dp_valid   = (state == ISSUE);
    dp_ray     = ray_q;
    dp_index   = dp_valid ? PI_W'(issue_cnt) : '0;
    resp_valid = (state == RESP);
    resp_id    = resp_valid ? id_q      : '0;
    resp_hit   = resp_valid ? best_hit  : 1'b0;
    resp_index = resp_valid ? best_idx  : '0;
    resp_data  = resp_valid ? best_data : '0;
  end

endmodule

// File: tb/tb_sphere_hit_scheduler.sv
// Scoreboard bench for sphere_hit_scheduler with a fixed-latency datapath model.
module tb_sphere_hit_scheduler;
  import sphere_hit_pkg::*;

  localparam int unsigned NR  = 4;
  localparam int unsigned NS  = 8;
  localparam int unsigned PW  = 8;
  localparam int unsigned IDW = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           hit;
    logic [PW-1:0]  idx;
    hit_data_t      data;
  } exp_t;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [NR-1:0]   req_valid;
  ray_t            req_ray [NR];
  logic [NR-1:0]   req_ready;
  logic            dp_valid;
  ray_t            dp_ray;
  logic [PW-1:0]   dp_index;
  logic            dp_res_valid;
  logic            dp_res_hit;
  fixed_t          dp_res_t;
  hit_data_t       dp_res_data;
  logic            resp_valid;
  logic [IDW-1:0]  resp_id;
  logic            resp_hit;
  logic [PW-1:0]   resp_index;
  hit_data_t       resp_data;
  logic            resp_ready;

  sphere_hit_scheduler #(.NUM_REQ(NR), .NUM_SPHERES(NS), .PI_W(PW)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ray(req_ray), .req_ready(req_ready),
    .dp_valid(dp_valid), .dp_ray(dp_ray), .dp_index(dp_index),
    .dp_res_valid(dp_res_valid), .dp_res_hit(dp_res_hit), .dp_res_t(dp_res_t),
    .dp_res_data(dp_res_data),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_hit(resp_hit),
    .resp_index(resp_index), .resp_data(resp_data), .resp_ready(resp_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Datapath model: per-sphere hit table, fixed latency lat.
  bit          sph_hit [NS];
  fixed_t      sph_t   [NS];
  logic [2:0]  lat = 3'd3;
  bit          pv   [8];
  bit [PW-1:0] pidx [8];
  ray_t        pray [8];
  bit [PW-1:0] ri;
  ray_t        rr;

  function automatic hit_data_t mk_data(input bit [PW-1:0] idx, input ray_t r, input fixed_t t);
    hit_data_t d;
    d.t  = t;
    d.nx = r.ox + $signed({24'd0, idx});
    d.ny = r.dx;
    d.nz = $signed({16'd0, idx, 8'd0});
    return d;
  endfunction

  always @(posedge clk) begin
    pv[0]   <= dp_valid;
    pidx[0] <= dp_index;
    pray[0] <= dp_ray;
    for (int i = 1; i < 8; i++) begin
      pv[i]   <= pv[i-1];
      pidx[i] <= pidx[i-1];
      pray[i] <= pray[i-1];
    end
  end

  always_comb begin
    dp_res_valid = pv[lat - 3'd1];
    ri           = pidx[lat - 3'd1];
    rr           = pray[lat - 3'd1];
    dp_res_hit   = sph_hit[ri[2:0]];
    dp_res_t     = dp_res_hit ? sph_t[ri[2:0]] : fixed_t'(1);
    dp_res_data  = mk_data(ri, rr, dp_res_t);
  end

  // Reference closest-hit for the table currently loaded.
  function automatic exp_t expect_for(input logic [IDW-1:0] id);
    exp_t   e;
    fixed_t bt;
    e    = '0;
    e.id = id;
    bt   = '0;
    for (int i = 0; i < NS; i++) begin
      if (sph_hit[i] && (!e.hit || sph_t[i] < bt)) begin
        e.hit  = 1'b1;
        bt     = sph_t[i];
        e.idx  = PW'(i);
        e.data = mk_data(PW'(i), req_ray[id], sph_t[i]);
      end
    end
    return e;
  endfunction

  exp_t           sb[$];
  logic [IDW-1:0] glog[$];
  int             grant_cyc = 0;

  // Monitor: push on grant, pop on accepted response, check issue order.
  initial begin
    exp_t           e;
    logic [IDW-1:0] g;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if ((req_ready & req_valid) != '0) begin
          g = '0;
          for (int i = 0; i < NR; i++) if (req_ready[i]) g = IDW'(i);
          sb.push_back(expect_for(g));
          glog.push_back(g);
          grant_cyc = cyc;
        end
        if (dp_valid) check("dp_index", 256'(dp_index), 256'(cyc - grant_cyc - 1));
        if (resp_valid && resp_ready) begin
          check("sb_pending", 256'(sb.size() > 0), 256'(1));
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("resp_id",    256'(resp_id),    256'(e.id));
            check("resp_hit",   256'(resp_hit),   256'(e.hit));
            check("resp_index", 256'(resp_index), 256'(e.idx));
            check("resp_data",  256'(resp_data),  256'(e.data));
          end
        end
      end
    end
  end

  task automatic clear_table();
    for (int i = 0; i < NS; i++) begin
      sph_hit[i] = 1'b0;
      sph_t[i]   = fixed_t'(32'h0001_0000 * (i + 1));
    end
  endtask

  task automatic wait_grant(output int g);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((req_ready & req_valid) == '0) && n < 200);
    check("grant_timeout", 256'(n < 200), 256'(1));
    g = cyc;
  endtask

  task automatic wait_resp(output int r);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 200);
    check("resp_timeout", 256'(n < 200), 256'(1));
    r = cyc;
  endtask

  task automatic do_query(input logic [NR-1:0] who, input logic [NR-1:0] exp_grant,
                          input logic [2:0] l, input int exp_delay, input string tag,
                          output exp_t got);
    int g;
    int r;
    if (l != lat) begin
      repeat (10) @(posedge clk);
      #1;
      lat = l;
    end
    req_valid = who;
    wait_grant(g);
    check({tag, "_grant"}, 256'(req_ready), 256'(exp_grant));
    @(posedge clk); #1;
    req_valid = '0;
    wait_resp(r);
    check({tag, "_lat"}, 256'(r - g), 256'(exp_delay));
    got = {resp_id, resp_hit, resp_index, resp_data};
    @(posedge clk); #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_ready"}, 256'(req_ready), 256'(0));
    check({tag, "_dp"}, 256'({dp_valid, dp_index}), 256'(0));
    check({tag, "_resp"}, 256'({resp_valid, resp_id, resp_hit, resp_index, resp_data}), 256'(0));
  endtask

  initial begin
    exp_t got, ref1, snap;
    int   g, r;
    for (int i = 0; i < NR; i++) begin
      req_ray[i]    = '0;
      req_ray[i].ox = fixed_t'((i + 1) << 16);
      req_ray[i].oy = fixed_t'(i * 5);
      req_ray[i].dx = fixed_t'(i * 3 + 7);
    end
    req_valid  = 4'b0100;
    resp_ready = 1'b1;
    clear_table();
    sph_hit[5] = 1'b1;
    sph_t[5]   = fixed_t'(32'h0003_0000);

    // Reset state, with a requester already asking.
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    resetn = 1'b1;
    @(negedge clk);
    check("ready_before_first_edge", 256'(req_ready), 256'(0));

    // Single query from requester 2, L=3.
    do_query(4'b0100, 4'b0100, 3'd3, 12, "single", ref1);
    check("single_id",  256'(ref1.id),  256'(2));
    check("single_hit", 256'(ref1.hit), 256'(1));
    check("single_idx", 256'(ref1.idx), 256'(5));

    // Latency independence.
    do_query(4'b0100, 4'b0100, 3'd1, 10, "lat1", got);
    check("lat1_same", 256'(got), 256'(ref1));
    do_query(4'b0100, 4'b0100, 3'd7, 16, "lat7", got);
    check("lat7_same", 256'(got), 256'(ref1));

    // Closest hit with a tie, then no hit at all.
    clear_table();
    sph_hit[1] = 1'b1; sph_t[1] = fixed_t'(32'h0005_0000);
    sph_hit[3] = 1'b1; sph_t[3] = fixed_t'(32'h0002_0000);
    sph_hit[6] = 1'b1; sph_t[6] = fixed_t'(32'h0002_0000);
    do_query(4'b0001, 4'b0001, 3'd3, 12, "tie", got);
    check("tie_idx", 256'(got.idx), 256'(3));
    check("tie_t",   256'(got.data.t), 256'(32'h0002_0000));
    clear_table();
    do_query(4'b0010, 4'b0010, 3'd3, 12, "nohit", got);
    check("nohit_hit", 256'(got.hit), 256'(0));
    check("nohit_idx", 256'(got.idx), 256'(0));

    // Backpressure with another requester waiting.
    sph_hit[2] = 1'b1; sph_t[2] = fixed_t'(32'h0000_8000);
    resp_ready = 1'b0;
    req_valid  = 4'b0010;
    wait_grant(g);
    check("bp_grant", 256'(req_ready), 256'(4'b0010));
    @(posedge clk); #1;
    req_valid = 4'b1000;
    wait_resp(r);
    check("bp_lat", 256'(r - g), 256'(12));
    snap = {resp_id, resp_hit, resp_index, resp_data};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", 256'({resp_valid, resp_id, resp_hit, resp_index, resp_data}),
            256'({1'b1, snap}));
      check("bp_no_grant", 256'(req_ready), 256'(0));
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_accept_cycle", 256'(resp_valid), 256'(1));
    @(negedge clk);
    check("bp_next_grant", 256'(req_ready), 256'(4'b1000));
    @(posedge clk); #1;
    req_valid = '0;
    wait_resp(r);
    @(posedge clk); #1;

    // Round-robin fairness from a fresh reset.
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    glog.delete();
    resetn    = 1'b1;
    req_valid = 4'b1111;
    begin
      int n = 0;
      while (glog.size() < 5 && n < 400) begin @(negedge clk); n++; end
      check("rr_phase1_timeout", 256'(n < 400), 256'(1));
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      n = 0;
      while (glog.size() < 9 && n < 400) begin @(negedge clk); n++; end
      check("rr_phase2_timeout", 256'(n < 400), 256'(1));
      @(posedge clk); #1;
      req_valid = '0;
    end
    begin
      logic [IDW-1:0] exp_seq [9];
      exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3, 2'd0, 2'd2};
      for (int i = 0; i < 9; i++) begin
        check($sformatf("rr_grant%0d", i), 256'((glog.size() > i) ? glog[i] : 2'bxx),
              256'(exp_seq[i]));
      end
    end
    wait_resp(r);
    @(posedge clk); #1;

    // Reset while in DRAIN with two results in flight.
    clear_table();
    sph_hit[6] = 1'b1; sph_t[6] = fixed_t'(32'h0000_1000);
    sph_hit[7] = 1'b1; sph_t[7] = fixed_t'(32'h0000_0800);
    req_valid = 4'b0001;
    wait_grant(g);
    @(posedge clk); #1;
    req_valid = '0;
    while (cyc < g + 9) @(negedge clk);
    check("mid_in_drain", 256'({dp_valid, resp_valid}), 256'(0));
    resetn    = 1'b0;
    req_valid = 4'b0010;
    #1;
    check_outputs_zero("mid_reset");
    req_valid = '0;
    #2;
    resetn = 1'b1;
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stale_ignored", 256'({resp_valid, dp_valid, req_ready}), 256'(0));
    end
    @(posedge clk); #1;
    clear_table();
    sph_hit[4] = 1'b1; sph_t[4] = fixed_t'(32'h0001_2000);
    do_query(4'b1000, 4'b1000, 3'd3, 12, "after_reset", got);
    check("after_reset_id",  256'(got.id),  256'(3));
    check("after_reset_idx", 256'(got.idx), 256'(4));

    repeat (5) @(posedge clk);
    check("sb_drained", 256'(sb.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
